// File: rtl/vga_tile_fb_if.sv
// vga_tile_fb_if: MCU-side tile write, clear and bank-swap port of vga_tile_fb.
interface vga_tile_fb_if #(parameter int AW = 4);
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_color;
  logic          clr_req;
  logic [7:0]    clr_color;
  logic          swap_req;
  logic          swap_pending;
  modport master (output wr_valid, wr_addr, wr_color, clr_req, clr_color, swap_req,
                  input wr_ready, swap_pending);
  modport slave (input wr_valid, wr_addr, wr_color, clr_req, clr_color, swap_req,
                 output wr_ready, swap_pending);
endinterface

// File: rtl/vga_tile_fb.sv
// vga_tile_fb: solid-colour tile framebuffer with VGA timing and a clear engine;
// define VGA_TILE_FB_DBUF_EN for vblank-synchronised double buffering.
module vga_tile_fb #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int GRID_X_BITS = 2,
  parameter int GRID_Y_BITS = 2
) (
  input  logic             clk,
  input  logic             rst,
  vga_tile_fb_if.slave     bus,
  output logic             frame_start,
  output logic [2:0]       vgaRed,
  output logic [2:0]       vgaGreen,
  output logic [1:0]       vgaBlue,
  output logic             Hsync,
  output logic             Vsync
);
  localparam int AW     = GRID_X_BITS + GRID_Y_BITS;
  localparam int TILE_W = H_ACTIVE >> GRID_X_BITS;
  localparam int TILE_H = V_ACTIVE >> GRID_Y_BITS;
  localparam int H_TOT  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW     = $clog2(H_TOT);
  localparam int VW     = $clog2(V_TOT);
  localparam int TXW    = $clog2(TILE_W + 1);
  localparam int TYW    = $clog2(TILE_H + 1);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOT - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOT - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [TXW-1:0] TX_LAST = TXW'(TILE_W - 1);
  localparam logic [TYW-1:0] TY_LAST = TYW'(TILE_H - 1);
  localparam logic [1:0] INIT_CLR = 2'd0;
  localparam logic [1:0] IDLE     = 2'd1;
  localparam logic [1:0] CLR      = 2'd2;

  logic [HW-1:0]          hcnt;
  logic [VW-1:0]          vcnt;
  logic [TXW-1:0]         tx;
  logic [TYW-1:0]         ty;
  logic [GRID_X_BITS-1:0] col;
  logic [GRID_Y_BITS-1:0] row;
  logic [1:0]             state;
  logic [AW-1:0]          cnt, wa, ra;
  logic [7:0]             clr_lat, pix, rd, wd;
  logic                   h_wrap, v_wrap, acc, we;
  logic [7:0]             mem0 [2**AW];

  assign h_wrap       = hcnt == H_LAST;
  assign v_wrap       = vcnt == V_LAST;
  assign frame_start  = hcnt == '0 && vcnt == V_ACT;
  assign bus.wr_ready = state == IDLE && !bus.clr_req;
  assign acc          = bus.wr_valid && bus.wr_ready;
  assign ra           = {row, col};
  assign wa           = state == IDLE ? bus.wr_addr : cnt;
  assign wd           = state == CLR ? clr_lat : state == IDLE ? bus.wr_color : 8'h00;
  assign we           = state != IDLE || acc;
  assign {vgaRed, vgaGreen, vgaBlue} = pix;

  // tile column/row follow the beam with sub-tile counters instead of dividing
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      hcnt  <= '0;
      vcnt  <= '0;
      tx    <= '0;
      ty    <= '0;
      col   <= '0;
      row   <= '0;
      Hsync <= 1'b1;
      Vsync <= 1'b1;
      pix   <= 8'h00;
    end else begin
      hcnt <= h_wrap ? '0 : hcnt + 1'b1;
      if (h_wrap) vcnt <= v_wrap ? '0 : vcnt + 1'b1;
      if (h_wrap) begin
        tx  <= '0;
        col <= '0;
      end else if (hcnt < H_ACT) begin
        tx <= tx == TX_LAST ? '0 : tx + 1'b1;
        if (tx == TX_LAST) col <= col + 1'b1;
      end
      if (h_wrap && v_wrap) begin
        ty  <= '0;
        row <= '0;
      end else if (h_wrap && vcnt < V_ACT) begin
        ty <= ty == TY_LAST ? '0 : ty + 1'b1;
        if (ty == TY_LAST) row <= row + 1'b1;
      end
      Hsync <= !(hcnt >= HS_BEG && hcnt < HS_END);
      Vsync <= !(vcnt >= VS_BEG && vcnt < VS_END);
      pix   <= hcnt < H_ACT && vcnt < V_ACT && state != INIT_CLR ? rd : 8'h00;
    end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state   <= INIT_CLR;
      cnt     <= '0;
      clr_lat <= 8'h00;
    end else if (state != IDLE) begin
      cnt <= cnt + 1'b1;
      if (cnt == '1) state <= IDLE;
    end else if (bus.clr_req) begin
      state   <= CLR;
      cnt     <= '0;
      clr_lat <= bus.clr_color;
    end

`ifdef VGA_TILE_FB_DBUF_EN
  logic [7:0] mem1 [2**AW];
  logic       front, pend, do_swap;
  assign do_swap          = frame_start && state == IDLE && pend;
  assign bus.swap_pending = pend;
  assign rd               = front ? mem1[ra] : mem0[ra];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      front <= 1'b0;
      pend  <= 1'b0;
    end else begin
      front <= front ^ do_swap;
      pend  <= bus.swap_req || (pend && !do_swap);
    end
  // INIT_CLR zeroes both banks together; otherwise only the back bank is written
  always_ff @(posedge clk) begin
    if (we && (state == INIT_CLR || front)) mem0[wa] <= wd;
    if (we && (state == INIT_CLR || !front)) mem1[wa] <= wd;
  end
`else
  logic unused_swap;
  assign unused_swap      = bus.swap_req;
  assign bus.swap_pending = 1'b0;
  assign rd               = mem0[ra];
  always_ff @(posedge clk)
    if (we) mem0[wa] <= wd;
`endif
endmodule

// File: tb/tb_vga_tile_fb.sv
// tb_vga_tile_fb: two scaled-timing instances (4x4 and 8x2 grids) fed identical
// MCU traffic and compared every cycle against a tile-memory reference model.
module tb_vga_tile_fb;
  localparam int HA = 64, HFP = 4, HS = 8, HBP = 4;
  localparam int VA = 32, VFP = 2, VS = 2, VBP = 4;
  localparam int HT = HA + HFP + HS + HBP, VT = VA + VFP + VS + VBP, FT = HT * VT, NT = 16;
  localparam int FS_POS = VA * HT;
`ifdef VGA_TILE_FB_DBUF_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1;
  logic fs1, fs2, hs1, hs2, vs1, vs2;
  logic [2:0] r1, g1, r2, g2;
  logic [1:0] b1, b2;
  vga_tile_fb_if #(.AW(4)) bus ();
  vga_tile_fb_if #(.AW(4)) bus2 ();
  assign bus2.wr_valid  = bus.wr_valid;
  assign bus2.wr_addr   = bus.wr_addr;
  assign bus2.wr_color  = bus.wr_color;
  assign bus2.clr_req   = bus.clr_req;
  assign bus2.clr_color = bus.clr_color;
  assign bus2.swap_req  = bus.swap_req;

  always #5 clk = ~clk;

  vga_tile_fb #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP), .V_ACTIVE(VA), .V_FP(VFP),
    .V_SYNC(VS), .V_BP(VBP), .GRID_X_BITS(2), .GRID_Y_BITS(2)) dut (.clk(clk), .rst(rst),
    .bus(bus), .frame_start(fs1), .vgaRed(r1), .vgaGreen(g1), .vgaBlue(b1), .Hsync(hs1), .Vsync(vs1));
  vga_tile_fb #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP), .V_ACTIVE(VA), .V_FP(VFP),
    .V_SYNC(VS), .V_BP(VBP), .GRID_X_BITS(3), .GRID_Y_BITS(1)) dut2 (.clk(clk), .rst(rst),
    .bus(bus2), .frame_start(fs2), .vgaRed(r2), .vgaGreen(g2), .vgaBlue(b2), .Hsync(hs2), .Vsync(vs2));

  typedef struct {int e; int a; logic [7:0] c; int b;} ent_t;
  ent_t q[$];
  logic [7:0] m [2][NT];
  int checks = 0, errors = 0, n = 0, busy_until = NT, hl = 0, vl = 0;
  bit front = 1'b0, pend = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_pix(int gx, int gy, int p);
    int x = p % HT, y = (p / HT) % VT;
    if (x >= HA || y >= VA || n <= NT) return 8'h00;
    return m[DB ? int'(front) : 0][((y / (VA >> gy)) << gx) + x / (HA >> gx)];
  endfunction

  task automatic step();
    bit idle, acc, clr, sw, sr, hexp, vexp;
    logic [3:0] a;
    logic [7:0] c, cc;
    int x, y;
    #1;
    idle = n >= busy_until;
    chk("wr_ready", bus.wr_ready, idle && !bus.clr_req);
    chk("wr_ready2", bus2.wr_ready, idle && !bus.clr_req);
    clr = idle && bus.clr_req;
    acc = idle && !bus.clr_req && bus.wr_valid;
    sw  = DB && pend && idle && (n % FT == FS_POS);
    sr  = bus.swap_req;
    a   = bus.wr_addr;
    c   = bus.wr_color;
    cc  = bus.clr_color;
    @(posedge clk);
    n++;
    #1;
    x = (n - 1) % HT;
    y = ((n - 1) / HT) % VT;
    hexp = !(x >= HA + HFP && x < HA + HFP + HS);
    vexp = !(y >= VA + VFP && y < VA + VFP + VS);
    chk("pix", {r1, g1, b1}, exp_pix(2, 2, n - 1));
    chk("pix2", {r2, g2, b2}, exp_pix(3, 1, n - 1));
    chk("hsync", hs1, hexp);
    chk("hsync2", hs2, hexp);
    chk("vsync", vs1, vexp);
    chk("vsync2", vs2, vexp);
    chk("frame_start", fs1, n % FT == FS_POS);
    chk("frame_start2", fs2, n % FT == FS_POS);
    hl += int'(!hs1);
    vl += int'(!vs1);
    if (acc) m[DB ? int'(!front) : 0][a] = c;
    while (q.size() > 0 && q[0].e == n) begin
      m[q[0].b][q[0].a] = q[0].c;
      void'(q.pop_front());
    end
    if (sw) front = !front;
    if (clr) begin
      busy_until = n + NT;
      for (int i = 0; i < NT; i++) q.push_back('{n + 1 + i, i, cc, DB ? int'(!front) : 0});
    end
    pend = DB && (sr || (pend && !sw));
    chk("swap_pending", bus.swap_pending, pend);
    chk("swap_pending2", bus2.swap_pending, pend);
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  task automatic go_to(input int pos);
    for (int i = 0; i <= FT && n % FT != pos; i++) step();
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] c);
    bus.wr_valid = 1'b1;
    bus.wr_addr  = a;
    bus.wr_color = c;
    step();
    bus.wr_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_pix", {r1, g1, b1, r2, g2, b2}, 0);
    chk("rst_sync", {hs1, vs1, hs2, vs2}, 4'hF);
    chk("rst_ready", {bus.wr_ready, bus2.wr_ready}, 0);
    chk("rst_pending", {bus.swap_pending, bus2.swap_pending}, 0);
    chk("rst_fs", {fs1, fs2}, 0);
    @(posedge clk);
    #1;
    n = 0;
    busy_until = NT;
    front = 1'b0;
    pend = 1'b0;
    q.delete();
    for (int b = 0; b < 2; b++) for (int i = 0; i < NT; i++) m[b][i] = 8'h00;
    rst = 1'b0;
  endtask

  initial begin
    int lo;
    bus.wr_valid = 1'b0; bus.wr_addr = '0; bus.wr_color = '0;
    bus.clr_req = 1'b0; bus.clr_color = '0; bus.swap_req = 1'b0;
    do_reset();
    for (int i = 0; i < 64 && !bus.wr_ready; i++) step();
    chk("ready_rise", n, NT);
    go_to(0);
    hl = 0;
    vl = 0;
    run(3 * FT);
    chk("hsync_low", hl, 3 * VT * HS);
    chk("vsync_low", vl, 3 * HT * VS);
    wr(4'd5, 8'hE0);
    go_to(10 * HT + 20 + 1);
    chk("tile5", {r1, g1, b1}, DB ? 8'h00 : 8'hE0);
    go_to(10 * HT + 40 + 1);
    chk("tile6", {r1, g1, b1}, 8'h00);
    bus.wr_valid = 1'b1; bus.wr_addr = 4'd3; bus.wr_color = 8'hAA;
    bus.clr_req = 1'b1; bus.clr_color = 8'h1C;
    step();
    bus.wr_valid = 1'b0; bus.clr_req = 1'b0;
    lo = 0;
    for (int i = 0; i < NT; i++) begin
      lo += int'(!bus.wr_ready);
      step();
    end
    chk("clr_busy", lo, NT);
    chk("clr_done", bus.wr_ready, 1);
    go_to(3 * HT + 50 + 1);
    chk("clr_tile3", {r1, g1, b1}, DB ? 8'h00 : 8'h1C);
    wr(4'd0, 8'h03);
    go_to(5 * HT);
    bus.swap_req = 1'b1;
    step();
    bus.swap_req = 1'b0;
    go_to(FS_POS + 1);
    chk("swap_done", bus.swap_pending, 0);
    go_to(2 * HT + 3 + 1);
    chk("tile0_blue", {r1, g1, b1}, 8'h03);
    go_to(FS_POS - 10);
    bus.swap_req = 1'b1;
    step();
    bus.swap_req = 1'b0;
    go_to(FS_POS - 5);
    bus.clr_req = 1'b1;
    bus.clr_color = 8'($urandom);
    step();
    bus.clr_req = 1'b0;
    go_to(FS_POS + 2);
    chk("swap_deferred", bus.swap_pending, DB);
    go_to(FS_POS + 1);
    chk("swap_late", bus.swap_pending, 0);
    for (int i = 0; i < 4000; i++) begin
      bus.wr_valid  = $urandom_range(3) == 0;
      bus.wr_addr   = 4'($urandom);
      bus.wr_color  = 8'($urandom);
      bus.clr_req   = $urandom_range(199) == 0;
      bus.clr_color = 8'($urandom);
      bus.swap_req  = $urandom_range(299) == 0;
      step();
    end
    bus.wr_valid = 1'b0; bus.clr_req = 1'b0; bus.swap_req = 1'b0;
    run(20);
    bus.clr_req = 1'b1;
    bus.clr_color = 8'h5A;
    step();
    bus.clr_req = 1'b0;
    run(5);
    do_reset();
    run(20);
    wr(4'd15, 8'hFF);
    go_to(20 * HT + 60 + 1);
    chk("grid8x2_tile15", {r2, g2, b2}, DB ? 8'h00 : 8'hFF);
    chk("grid4x4_tile11", {r1, g1, b1}, 8'h00);
    go_to(0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
